// File: rtl/arbmux_if.sv
// Bundle of handshake and data signals for the arbitrating mux.
//   in_valid  [N]     per-channel request from the producers
//   in_data   [N*DW]  concatenated producer data {..,in1,in0}
//   in_ready  [N]     per-channel accept (one-hot or zero)
//   out_valid         output register holds a valid word
//   out_data  [DW]    registered selected word
//   out_grant [N]     one-hot source channel of out_data
//   out_ready         downstream accept
// slave  : the mux itself
// master : the environment (producers plus consumer)
interface arbmux_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned N  = 4
) ();
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [N-1:0]    out_grant;
  logic            out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_grant
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_grant
  );
endinterface

// File: rtl/arbmux.sv
// N-channel arbitrating mux with a single registered output stage.
// A round-robin or fixed-priority arbiter picks one requesting channel per
// cycle; its word is captured through a one-hot AND-OR select.
//   clk     clock, all state on the rising edge
//   nreset  synchronous active-low reset
//   bus     arbmux_if.slave (per-channel valid/ready/data in, registered out)
module arbmux #(
  parameter int unsigned DW = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned RR = 1
) (
  input  logic     clk,
  input  logic     nreset,
  arbmux_if.slave  bus
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_last;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [N-1:0]  r_out_grant;

  logic          w_load;
  logic [N-1:0]  w_grant;
  logic [N-1:0]  w_ready;
  logic [PW-1:0] w_gidx;
  logic          w_found;
  logic          w_xfer;
  logic [DW-1:0] w_data;

  // Output register can take a new word whenever it is empty or draining.
  assign w_load = ~r_out_valid | bus.out_ready;

  // Arbiter: scan from (last+1) mod N in round-robin mode, from 0 otherwise.
  // With a single channel the grant is unconditional so ready tracks load only.
  always_comb begin : p_grant
    logic [PW-1:0] idx;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (RR != 0) idx = PW'((32'(r_last) + 32'd1 + k) % N);
      else         idx = PW'(k);
      if (!w_found && ((N == 1) || bus.in_valid[idx])) begin
        w_grant[idx] = 1'b1;
        w_gidx       = idx;
        w_found      = 1'b1;
      end
    end
  end

  assign w_ready = w_grant & {N{w_load & nreset}};
  assign w_xfer  = |(bus.in_valid & w_ready);

  // One-hot AND-OR data select.
  always_comb begin : p_mux
    w_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_data = w_data | ({DW{w_grant[i]}} & bus.in_data[i*DW +: DW]);
    end
  end

  // Output stage and round-robin pointer; pointer moves only on a transfer.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_grant <= '0;
      r_last      <= PW'(N - 1);
    end else if (w_load) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_grant <= w_grant;
        if (RR != 0) r_last <= w_gidx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_grant = r_out_grant;

endmodule

// File: tb/tb_arbmux.sv
// Directed bench for arbmux: one round-robin and one fixed-priority instance.
module tb_arbmux;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;

  logic clk;
  logic nreset;

  int n_checks;
  int n_errors;
  int cnt [N];

  arbmux_if #(.DW(DW), .N(N)) if_rr ();
  arbmux_if #(.DW(DW), .N(N)) if_fp ();

  arbmux #(.DW(DW), .N(N), .RR(1)) u_rr (
    .clk    (clk),
    .nreset (nreset),
    .bus    (if_rr.slave)
  );

  arbmux #(.DW(DW), .N(N), .RR(0)) u_fp (
    .clk    (clk),
    .nreset (nreset),
    .bus    (if_fp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dval(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int j = 0; j < int'(N); j++) cnt[j] = 0;

    // Reset held two cycles with every channel requesting.
    nreset          = 1'b0;
    if_rr.in_valid  = 4'b1111;
    if_fp.in_valid  = 4'b1111;
    if_rr.out_ready = 1'b1;
    if_fp.out_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if_rr.in_data[i*DW +: DW] = dval(i);
      if_fp.in_data[i*DW +: DW] = dval(i);
    end
    tick();
    tick();
    check("rst_in_ready", 64'(if_rr.in_ready), 64'd0);
    check("rst_out_valid", 64'(if_rr.out_valid), 64'd0);
    check("rst_out_data", 64'(if_rr.out_data), 64'd0);
    check("rst_out_grant", 64'(if_rr.out_grant), 64'd0);
    check("rst_fp_in_ready", 64'(if_fp.in_ready), 64'd0);
    check("rst_fp_out_valid", 64'(if_fp.out_valid), 64'd0);

    // Fixed priority: channels 1 and 3 request, channel 1 always wins.
    nreset         = 1'b1;
    if_rr.in_valid = 4'b0000;
    if_fp.in_valid = 4'b1010;
    #1;
    check("fp_in_ready", 64'(if_fp.in_ready), 64'b0010);
    check("rr_idle_ready", 64'(if_rr.in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fp_out_valid", 64'(if_fp.out_valid), 64'd1);
      check("fp_out_grant", 64'(if_fp.out_grant), 64'b0010);
      check("fp_out_data", 64'(if_fp.out_data), 64'(dval(1)));
      check("fp_in_ready_hold", 64'(if_fp.in_ready), 64'b0010);
    end
    if_fp.in_valid = 4'b0000;

    // Round-robin with all channels requesting: 0,1,2,3,0,1,2,3.
    if_rr.in_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      logic [N-1:0] exp_g;
      exp_g = N'(1) << (c % 4);
      #1;
      check("rr_in_ready", 64'(if_rr.in_ready), 64'(exp_g));
      tick();
      check("rr_out_valid", 64'(if_rr.out_valid), 64'd1);
      check("rr_out_grant", 64'(if_rr.out_grant), 64'(exp_g));
      check("rr_out_data", 64'(if_rr.out_data), 64'(dval(c % 4)));
      for (int j = 0; j < int'(N); j++)
        if (if_rr.out_grant[j]) cnt[j]++;
    end
    for (int j = 0; j < int'(N); j++) check("rr_fair_count", 64'(cnt[j]), 64'd2);

    // Wrap/skip: last=3, only ch2 -> ch2; then ch0|ch1 from last=2 -> search 3,0 -> ch0.
    if_rr.in_valid = 4'b0100;
    #1;
    check("skip_in_ready", 64'(if_rr.in_ready), 64'b0100);
    tick();
    check("skip_out_grant", 64'(if_rr.out_grant), 64'b0100);
    check("skip_out_data", 64'(if_rr.out_data), 64'(dval(2)));
    if_rr.in_valid = 4'b0011;
    #1;
    check("wrap_in_ready", 64'(if_rr.in_ready), 64'b0001);
    tick();
    check("wrap_out_grant", 64'(if_rr.out_grant), 64'b0001);
    check("wrap_out_data", 64'(if_rr.out_data), 64'(dval(0)));

    // Backpressure: load ch2 word, stall three cycles, then drain and refill.
    if_rr.in_data[2*DW +: DW] = 32'hA5A5_A5A5;
    if_rr.in_valid = 4'b0100;
    tick();
    check("bp_load_data", 64'(if_rr.out_data), 64'h0000_0000_A5A5_A5A5);
    check("bp_load_grant", 64'(if_rr.out_grant), 64'b0100);
    if_rr.out_ready = 1'b0;
    if_rr.in_valid  = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", 64'(if_rr.in_ready), 64'd0);
      tick();
      check("bp_out_valid", 64'(if_rr.out_valid), 64'd1);
      check("bp_out_data", 64'(if_rr.out_data), 64'h0000_0000_A5A5_A5A5);
      check("bp_out_grant", 64'(if_rr.out_grant), 64'b0100);
    end
    if_rr.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(if_rr.in_ready), 64'b1000);
    tick();
    check("bp_refill_valid", 64'(if_rr.out_valid), 64'd1);
    check("bp_refill_grant", 64'(if_rr.out_grant), 64'b1000);
    check("bp_refill_data", 64'(if_rr.out_data), 64'(dval(3)));

    // Idle cycle: output empties, data/grant hold, pointer stays at 3.
    if_rr.in_valid = 4'b0000;
    tick();
    check("idle_out_valid", 64'(if_rr.out_valid), 64'd0);
    check("idle_out_data", 64'(if_rr.out_data), 64'(dval(3)));
    check("idle_out_grant", 64'(if_rr.out_grant), 64'b1000);
    if_rr.in_valid = 4'b1111;
    #1;
    check("idle_ptr_ready", 64'(if_rr.in_ready), 64'b0001);
    tick();
    check("idle_ptr_grant", 64'(if_rr.out_grant), 64'b0001);

    // Reset while holding a stalled word; pointer must return to favour ch0.
    if_rr.out_ready = 1'b0;
    nreset          = 1'b0;
    #1;
    check("mrst_in_ready", 64'(if_rr.in_ready), 64'd0);
    tick();
    check("mrst_out_valid", 64'(if_rr.out_valid), 64'd0);
    check("mrst_out_grant", 64'(if_rr.out_grant), 64'd0);
    nreset          = 1'b1;
    if_rr.out_ready = 1'b1;
    #1;
    check("mrst_first_ready", 64'(if_rr.in_ready), 64'b0001);
    tick();
    check("mrst_first_grant", 64'(if_rr.out_grant), 64'b0001);
    check("mrst_first_data", 64'(if_rr.out_data), 64'(dval(0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
